// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC-1 on load, one PC-2 round key per accepted handshake.
// Encrypt streams K1..K16 with left rotations, decrypt streams K16..K1 with right rotations.
// Optional build macro KEY_PARITY_CHECK_EN: rejects keys whose bytes lack odd parity.
module des_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    input  logic        key_ready,
    output logic [47:0] round_key,
    output logic        round_key_valid,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done,
    output logic        parity_err
);

    typedef enum logic [1:0] {StIdle, StEmit, StFin} state_e;

    // Zero-based source bit positions (FIPS table value minus one).
    localparam logic [5:0] PC1 [56] = '{
        56, 48, 40, 32, 24, 16,  8,  0, 57, 49, 41, 33, 25, 17,
         9,  1, 58, 50, 42, 34, 26, 18, 10,  2, 59, 51, 43, 35,
        62, 54, 46, 38, 30, 22, 14,  6, 61, 53, 45, 37, 29, 21,
        13,  5, 60, 52, 44, 36, 28, 20, 12,  4, 27, 19, 11,  3
    };
    localparam logic [5:0] PC2 [48] = '{
        13, 16, 10, 23,  0,  4,  2, 27, 14,  5, 20,  9,
        22, 18, 11,  3, 25,  7, 15,  6, 26, 19, 12,  1,
        40, 51, 30, 36, 46, 54, 29, 39, 50, 44, 32, 47,
        43, 48, 38, 55, 33, 52, 45, 41, 49, 35, 28, 31
    };

    function automatic logic [55:0] pc1_perm(input logic [63:0] k);
        logic [55:0] cd;
        for (int i = 0; i < 56; i++) cd[i] = k[PC1[i]];
        return cd;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
        logic [47:0] rk;
        for (int i = 0; i < 48; i++) rk[i] = cd[PC2[i]];
        return rk;
    endfunction

    // Rounds 1, 2, 9 and 16 shift by one; all others by two (r is 1-based).
    function automatic logic is_double(input logic [4:0] r);
        return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
    endfunction

    function automatic logic [27:0] rol1(input logic [27:0] h);
        return {h[0], h[27:1]};
    endfunction

    function automatic logic [27:0] ror1(input logic [27:0] h);
        return {h[26:0], h[27]};
    endfunction

    function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic right,
                                           input logic two);
        logic [27:0] c;
        logic [27:0] d;
        c = cd[27:0];
        d = cd[55:28];
        if (right) begin
            c = ror1(c);
            d = ror1(d);
            if (two) begin
                c = ror1(c);
                d = ror1(d);
            end
        end else begin
            c = rol1(c);
            d = rol1(d);
            if (two) begin
                c = rol1(c);
                d = rol1(d);
            end
        end
        return {d, c};
    endfunction

    state_e      state_q, state_d;
    logic [55:0] cd_q, cd_d;
    logic [47:0] round_key_q, round_key_d;
    logic [3:0]  round_idx_q, round_idx_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        decrypt_q, decrypt_d;
    logic [55:0] key_cd;
    logic        key_par_ok;

    assign key_cd = pc1_perm(key);

`ifdef KEY_PARITY_CHECK_EN
    logic parity_err_q, parity_err_d;

    // Every key byte must carry odd parity for a start to be honoured.
    always_comb begin
        key_par_ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (!(^key[8*k +: 8])) key_par_ok = 1'b0;
        end
    end

    // Flag a rejected start for exactly one cycle.
    always_comb parity_err_d = (state_q == StIdle) && start && !key_par_ok;

    // Parity error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_err_q <= 1'b0;
        else        parity_err_q <= parity_err_d;
    end

    assign parity_err = parity_err_q;
`else
    // Parity bits are not part of the key material when checking is off.
    logic unused_parity_bits;
    assign unused_parity_bits = ^{key[63], key[55], key[47], key[39],
                                  key[31], key[23], key[15], key[7]};
    assign key_par_ok = 1'b1;
    assign parity_err = 1'b0;
`endif

    // Next-state logic: load on start, advance on each accepted key, pulse done at the end.
    always_comb begin
        state_d     = state_q;
        cd_d        = cd_q;
        round_key_d = round_key_q;
        round_idx_d = round_idx_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        decrypt_d   = decrypt_q;
        case (state_q)
            StIdle: begin
                if (start && key_par_ok) begin
                    state_d     = StEmit;
                    decrypt_d   = decrypt;
                    // Decrypt starts at K16, whose C/D equal the unrotated PC-1 halves.
                    cd_d        = decrypt ? key_cd : rot_cd(key_cd, 1'b0, 1'b0);
                    round_key_d = pc2_perm(cd_d);
                    round_idx_d = 4'd0;
                    valid_d     = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            StEmit: begin
                if (key_ready) begin
                    if (round_idx_q == 4'd15) begin
                        state_d = StFin;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        if (decrypt_q) begin
                            cd_d = rot_cd(cd_q, 1'b1, is_double(5'd16 - {1'b0, round_idx_q}));
                        end else begin
                            cd_d = rot_cd(cd_q, 1'b0, is_double({1'b0, round_idx_q} + 5'd2));
                        end
                        round_key_d = pc2_perm(cd_d);
                        round_idx_d = round_idx_q + 4'd1;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Schedule state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cd_q        <= '0;
            round_key_q <= '0;
            round_idx_q <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            decrypt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cd_q        <= cd_d;
            round_key_q <= round_key_d;
            round_idx_q <= round_idx_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            decrypt_q   <= decrypt_d;
        end
    end

    assign round_key       = round_key_q;
    assign round_idx       = round_idx_q;
    assign round_key_valid = valid_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule
